// File: rtl/gng_input_pkg.sv
// Shared constants for the GnG player-input front end: PS/2 scancodes,
// bit positions of the HPS joystick and JAMMA buses, and the game's
// 6-bit joystick layout.
package gng_input_pkg;

    // PS/2 set-2 scancodes (extended prefix is ignored by the decoder)
    localparam logic [7:0] KEY_UP     = 8'h75;
    localparam logic [7:0] KEY_DOWN   = 8'h72;
    localparam logic [7:0] KEY_LEFT   = 8'h6B;
    localparam logic [7:0] KEY_RIGHT  = 8'h74;
    localparam logic [7:0] KEY_FIRE_A = 8'h14;
    localparam logic [7:0] KEY_FIRE_B = 8'h11;
    localparam logic [7:0] KEY_JUMP   = 8'h29;
    localparam logic [7:0] KEY_START1 = 8'h05;
    localparam logic [7:0] KEY_START2 = 8'h06;
    localparam logic [7:0] KEY_COIN   = 8'h04;
    localparam logic [7:0] KEY_PAUSE  = 8'h0C;

    // Game joystick bus {jump,fire,up,down,left,right}. The low six bits of
    // both the HPS joystick and the JAMMA port use this same order.
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_FIRE  = 4;
    localparam int BTN_JUMP  = 5;
    localparam int BTN_W     = 6;

    // HPS joystick extra buttons
    localparam int JOY_START1 = 6;
    localparam int JOY_START2 = 7;
    localparam int JOY_COIN   = 8;
    localparam int JOY_PAUSE  = 9;

    // JAMMA {coin,start,b2,b1,u,d,l,r}
    localparam int JAM_START = 6;
    localparam int JAM_COIN  = 7;

    // One latch per recognised key; the two fire keys are tracked separately
    // so releasing one does not cancel the other.
    typedef struct packed {
        logic pause;
        logic coin;
        logic start2;
        logic start1;
        logic jump;
        logic fire_b;
        logic fire_a;
        logic up;
        logic down;
        logic left;
        logic right;
    } key_latch_t;

    // Cancel opposing directions when enabled (active-high buttons).
    function automatic logic [BTN_W-1:0] socd_filter(input logic [BTN_W-1:0] btn,
                                                     input logic            enable);
        logic [BTN_W-1:0] res;
        // NOTE: res takes a full default before the conditional edits so every
        // path assigns every bit; the same rule keeps always_comb latch-free.
        res = btn;
        if (enable && btn[BTN_UP] && btn[BTN_DOWN]) begin
            res[BTN_UP]   = 1'b0;
            res[BTN_DOWN] = 1'b0;
        end
        if (enable && btn[BTN_LEFT] && btn[BTN_RIGHT]) begin
            res[BTN_LEFT]  = 1'b0;
            res[BTN_RIGHT] = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/gng_coin_pulse.sv
// Coin pulse stretcher: a rising edge on src while idle drives coin_n low
// for exactly COIN_CYC cycles. No retrigger; a held source never restarts.
module gng_coin_pulse #(
    parameter logic [22:0] COIN_CYC = 23'd2_400_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic coin_n
);

    logic        r_src_d;
    logic [22:0] r_cnt;

    // Edge-detect the source and run the pulse down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so r_src_d here still holds last
            // cycle's value when the edge test below reads it.
            r_src_d <= src;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 23'd1;
            end else if (src && !r_src_d) begin
                r_cnt <= COIN_CYC;
            end
        end
    end

    // Derived only from the counter register, so reset releases it at once.
    assign coin_n = (r_cnt == '0);

endmodule

// File: rtl/gng_input_ctrl.sv
// GnG input front end: merges PS/2 keys, two HPS joysticks and the two JAMMA
// ports into the active-low buses used by jtgng_game, with pause toggle and
// coin pulse stretching.
module gng_input_ctrl
    import gng_input_pkg::*;
#(
    parameter logic [22:0] COIN_CYC   = 23'd2_400_000,
    parameter logic        SOCD_CLEAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] ps2_key,
    input  logic [9:0]  joy_0,
    input  logic [9:0]  joy_1,
    input  logic [7:0]  jamma_p1,
    input  logic [7:0]  jamma_p2,
    input  logic        soft_rst,
    output logic [5:0]  joystick1,
    output logic [5:0]  joystick2,
    output logic [1:0]  start_button,
    output logic [1:0]  coin_input,
    output logic        pause
);

    logic             r_ps2_strobe;
    key_latch_t       r_keys;
    logic [7:0]       r_jp1_meta, r_jp1_sync;
    logic [7:0]       r_jp2_meta, r_jp2_sync;
    logic [BTN_W-1:0] r_joy1, r_joy2;
    logic [1:0]       r_start;
    logic             r_pause, r_pause_src_d;

    logic             w_ps2_event;
    logic [BTN_W-1:0] w_kbd_btn, w_p1_btn, w_p2_btn;
    logic [1:0]       w_start;
    logic             w_coin1_src, w_coin2_src, w_pause_src;
    logic             w_unused_ext;

    // Arrow and keypad-arrow codes differ only in the extended flag.
    assign w_unused_ext = ps2_key[8];
    assign w_ps2_event  = ps2_key[10] ^ r_ps2_strobe;

    // Track the PS/2 toggle strobe and update the addressed key latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ps2_strobe <= 1'b0;
            // NOTE: the key latches are plain flops, not a memory, so they are
            // cleared by reset like any other state.
            r_keys       <= '0;
        end else begin
            r_ps2_strobe <= ps2_key[10];
            if (w_ps2_event) begin
                case (ps2_key[7:0])
                    KEY_UP:     r_keys.up     <= ps2_key[9];
                    KEY_DOWN:   r_keys.down   <= ps2_key[9];
                    KEY_LEFT:   r_keys.left   <= ps2_key[9];
                    KEY_RIGHT:  r_keys.right  <= ps2_key[9];
                    KEY_FIRE_A: r_keys.fire_a <= ps2_key[9];
                    KEY_FIRE_B: r_keys.fire_b <= ps2_key[9];
                    KEY_JUMP:   r_keys.jump   <= ps2_key[9];
                    KEY_START1: r_keys.start1 <= ps2_key[9];
                    KEY_START2: r_keys.start2 <= ps2_key[9];
                    KEY_COIN:   r_keys.coin   <= ps2_key[9];
                    KEY_PAUSE:  r_keys.pause  <= ps2_key[9];
                    default:    ;
                endcase
            end
        end
    end

    // Two-flop synchronizers for the asynchronous JAMMA ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jp1_meta <= '0;
            r_jp1_sync <= '0;
            r_jp2_meta <= '0;
            r_jp2_sync <= '0;
        end else begin
            r_jp1_meta <= jamma_p1;
            r_jp1_sync <= r_jp1_meta;
            r_jp2_meta <= jamma_p2;
            r_jp2_sync <= r_jp2_meta;
        end
    end

    // Merge all sources (active-high) and apply direction cleaning.
    always_comb begin
        w_kbd_btn   = {r_keys.jump, r_keys.fire_a | r_keys.fire_b, r_keys.up,
                       r_keys.down, r_keys.left, r_keys.right};
        w_p1_btn    = socd_filter(w_kbd_btn | joy_0[BTN_W-1:0] | r_jp1_sync[BTN_W-1:0],
                                  SOCD_CLEAN);
        w_p2_btn    = socd_filter(joy_1[BTN_W-1:0] | r_jp2_sync[BTN_W-1:0], SOCD_CLEAN);
        w_start[0]  = r_keys.start1 | joy_0[JOY_START1] | joy_1[JOY_START1] | r_jp1_sync[JAM_START];
        w_start[1]  = r_keys.start2 | joy_0[JOY_START2] | joy_1[JOY_START2] | r_jp2_sync[JAM_START];
        w_coin1_src = r_keys.coin | joy_0[JOY_COIN] | r_jp1_sync[JAM_COIN];
        w_coin2_src = joy_1[JOY_COIN] | r_jp2_sync[JAM_COIN];
        w_pause_src = r_keys.pause | joy_0[JOY_PAUSE] | joy_1[JOY_PAUSE];
    end

    // Register inverted outputs; pause toggles on a source edge, soft_rst wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_joy1        <= '1;
            r_joy2        <= '1;
            r_start       <= 2'b11;
            r_pause       <= 1'b0;
            r_pause_src_d <= 1'b0;
        end else begin
            r_joy1        <= ~w_p1_btn;
            r_joy2        <= ~w_p2_btn;
            r_start       <= ~w_start;
            r_pause_src_d <= w_pause_src;
            if (soft_rst) begin
                r_pause <= 1'b0;
            end else if (w_pause_src && !r_pause_src_d) begin
                r_pause <= ~r_pause;
            end
        end
    end

    gng_coin_pulse #(.COIN_CYC(COIN_CYC)) u_coin1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .src    (w_coin1_src),
        .coin_n (coin_input[0])
    );

    gng_coin_pulse #(.COIN_CYC(COIN_CYC)) u_coin2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .src    (w_coin2_src),
        .coin_n (coin_input[1])
    );

    assign joystick1    = r_joy1;
    assign joystick2    = r_joy2;
    assign start_button = r_start;
    assign pause        = r_pause;

endmodule

// File: tb/tb_gng_input_ctrl.sv
// Testbench for gng_input_ctrl: scoreboard of expected output snapshots,
// pushed when stimulus is applied and popped as each clock's result appears.
module tb_gng_input_ctrl;

    localparam logic [22:0] COIN_CYC = 23'd8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] ps2_key;
    logic [9:0]  joy_0, joy_1;
    logic [7:0]  jamma_p1, jamma_p2;
    logic        soft_rst;
    logic [5:0]  joystick1, joystick2, raw_joystick1, raw_joystick2;
    logic [1:0]  start_button, coin_input, raw_start, raw_coin;
    logic        pause, raw_pause;

    int n_checks = 0;
    int n_pass   = 0;

    // snapshot layout {pause, coin_input, start_button, joystick2, joystick1}
    typedef struct {
        string       name;
        logic [16:0] exp;
    } sb_item_t;

    typedef struct {
        string       name;
        int          kind;   // 0 joy_0, 1 {soft_rst,joy_1}, 2 jamma_p1, 3 jamma_p2, 4 ps2 {ext,pressed,code}
        logic [10:0] val;
        int          lat;
        logic [16:0] exp;
    } step_t;

    sb_item_t    sb[$];
    logic [16:0] exp_now;

    always #5 clk = ~clk;

    gng_input_ctrl #(.COIN_CYC(COIN_CYC), .SOCD_CLEAN(1'b1)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_key      (ps2_key),
        .joy_0        (joy_0),
        .joy_1        (joy_1),
        .jamma_p1     (jamma_p1),
        .jamma_p2     (jamma_p2),
        .soft_rst     (soft_rst),
        .joystick1    (joystick1),
        .joystick2    (joystick2),
        .start_button (start_button),
        .coin_input   (coin_input),
        .pause        (pause)
    );

    gng_input_ctrl #(.COIN_CYC(COIN_CYC), .SOCD_CLEAN(1'b0)) u_raw (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_key      (ps2_key),
        .joy_0        (joy_0),
        .joy_1        (joy_1),
        .jamma_p1     (jamma_p1),
        .jamma_p2     (jamma_p2),
        .soft_rst     (soft_rst),
        .joystick1    (raw_joystick1),
        .joystick2    (raw_joystick2),
        .start_button (raw_start),
        .coin_input   (raw_coin),
        .pause        (raw_pause)
    );

    localparam logic [16:0] IDLE = {1'b0, 2'b11, 2'b11, 6'h3F, 6'h3F};

    function automatic logic [16:0] e_j1(input logic [5:0] v);
        return {1'b0, 2'b11, 2'b11, 6'h3F, v};
    endfunction
    function automatic logic [16:0] e_j2(input logic [5:0] v);
        return {1'b0, 2'b11, 2'b11, v, 6'h3F};
    endfunction
    function automatic logic [16:0] e_st(input logic [1:0] v);
        return {1'b0, 2'b11, v, 6'h3F, 6'h3F};
    endfunction
    function automatic logic [16:0] e_p(input logic v);
        return {v, 2'b11, 2'b11, 6'h3F, 6'h3F};
    endfunction

    function automatic logic [16:0] obs();
        return {pause, coin_input, start_button, joystick2, joystick1};
    endfunction

    function automatic step_t st(input string n, input int kind, input logic [10:0] v,
                                 input int lat, input logic [16:0] e);
        step_t s;
        s.name = n; s.kind = kind; s.val = v; s.lat = lat; s.exp = e;
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input step_t s);
        case (s.kind)
            0: joy_0 = s.val[9:0];
            1: begin joy_1 = s.val[9:0]; soft_rst = s.val[10]; end
            2: jamma_p1 = s.val[7:0];
            3: jamma_p2 = s.val[7:0];
            default: ps2_key = {~ps2_key[10], s.val[8], s.val[9], s.val[7:0]};
        endcase
    endtask

    task automatic test_reset();
        sb_item_t it;
        rst_n = 1'b0;
        joy_0 = '1; joy_1 = '1; jamma_p1 = '1; jamma_p2 = '1; soft_rst = 1'b1;
        ps2_key = 11'h3FF;
        sb.push_back('{"reset_hold", IDLE});
        tick(3);
        it = sb.pop_front();
        n_checks++;
        if (obs() !== it.exp) $display("FAIL %s: got %h expected %h", it.name, obs(), it.exp);
        else n_pass++;
        joy_0 = '0; joy_1 = '0; jamma_p1 = '0; jamma_p2 = '0; soft_rst = 1'b0;
        ps2_key = 11'h000;
        tick(1);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back('{$sformatf("reset_release@%0d", k + 1), IDLE});
        for (int k = 0; k < 3; k++) begin
            tick(1);
            it = sb.pop_front();
            n_checks++;
            if (obs() !== it.exp) $display("FAIL %s: got %h expected %h", it.name, obs(), it.exp);
            else n_pass++;
        end
        exp_now = IDLE;
    endtask

    task automatic test_ps2();
        step_t    steps[$];
        sb_item_t it;
        steps.push_back(st("kbd_left_press",    4, 11'h16B, 2, e_j1(6'h3D)));
        steps.push_back(st("kbd_left_release",  4, 11'h06B, 2, IDLE));
        steps.push_back(st("kbd_left_ext_press",4, 11'h36B, 2, e_j1(6'h3D)));
        steps.push_back(st("kbd_left_ext_rel",  4, 11'h26B, 2, IDLE));
        steps.push_back(st("kbd_unlisted_1c",   4, 11'h11C, 2, IDLE));
        steps.push_back(st("kbd_unlisted_rel",  4, 11'h01C, 2, IDLE));
        steps.push_back(st("kbd_up_press",      4, 11'h175, 2, e_j1(6'h37)));
        steps.push_back(st("kbd_right_press",   4, 11'h174, 2, e_j1(6'h36)));
        steps.push_back(st("kbd_up_release",    4, 11'h075, 2, e_j1(6'h3E)));
        steps.push_back(st("kbd_right_release", 4, 11'h074, 2, IDLE));
        steps.push_back(st("kbd_up_again",      4, 11'h175, 2, e_j1(6'h37)));
        steps.push_back(st("kbd_down_socd",     4, 11'h172, 2, IDLE));
        steps.push_back(st("kbd_up_rel_down",   4, 11'h075, 2, e_j1(6'h3B)));
        steps.push_back(st("kbd_down_release",  4, 11'h072, 2, IDLE));
        steps.push_back(st("kbd_fire14_press",  4, 11'h114, 2, e_j1(6'h2F)));
        steps.push_back(st("kbd_fire11_press",  4, 11'h111, 2, e_j1(6'h2F)));
        steps.push_back(st("kbd_fire14_rel",    4, 11'h014, 2, e_j1(6'h2F)));
        steps.push_back(st("kbd_fire11_rel",    4, 11'h011, 2, IDLE));
        steps.push_back(st("kbd_jump_press",    4, 11'h129, 2, e_j1(6'h1F)));
        steps.push_back(st("kbd_jump_release",  4, 11'h029, 2, IDLE));
        foreach (steps[i]) begin
            apply(steps[i]);
            for (int k = 1; k <= steps[i].lat; k++)
                sb.push_back('{$sformatf("%s@%0d", steps[i].name, k),
                               (k < steps[i].lat) ? exp_now : steps[i].exp});
            for (int k = 1; k <= steps[i].lat; k++) begin
                tick(1);
                it = sb.pop_front();
                n_checks++;
                if (obs() !== it.exp) $display("FAIL %s: got %h expected %h", it.name, obs(), it.exp);
                else n_pass++;
            end
            exp_now = steps[i].exp;
        end
    endtask

    task automatic test_socd();
        step_t    steps[$];
        sb_item_t it;
        steps.push_back(st("socd_p1_lr",      0, 11'h003, 1, IDLE));
        steps.push_back(st("socd_p1_up",      0, 11'h008, 1, e_j1(6'h37)));
        steps.push_back(st("socd_p1_ud",      0, 11'h00C, 1, IDLE));
        steps.push_back(st("socd_p1_udl",     0, 11'h00E, 1, e_j1(6'h3D)));
        steps.push_back(st("socd_p1_clear",   0, 11'h000, 1, IDLE));
        steps.push_back(st("socd_p2_all",     1, 11'h00F, 1, IDLE));
        steps.push_back(st("socd_p2_ud_left", 1, 11'h00E, 1, e_j2(6'h3D)));
        steps.push_back(st("socd_p2_clear",   1, 11'h000, 1, IDLE));
        foreach (steps[i]) begin
            apply(steps[i]);
            for (int k = 1; k <= steps[i].lat; k++)
                sb.push_back('{$sformatf("%s@%0d", steps[i].name, k),
                               (k < steps[i].lat) ? exp_now : steps[i].exp});
            for (int k = 1; k <= steps[i].lat; k++) begin
                tick(1);
                it = sb.pop_front();
                n_checks++;
                if (obs() !== it.exp) $display("FAIL %s: got %h expected %h", it.name, obs(), it.exp);
                else n_pass++;
            end
            exp_now = steps[i].exp;
        end
        // pass-through build keeps opposing directions
        joy_0 = 10'h003;
        sb.push_back('{"raw_lr", {11'b0, 6'h3C}});
        tick(1);
        it = sb.pop_front();
        n_checks++;
        if (raw_joystick1 !== it.exp[5:0]) $display("FAIL %s: got %h expected %h", it.name, raw_joystick1, it.exp[5:0]);
        else n_pass++;
        joy_0 = 10'h00C;
        sb.push_back('{"raw_ud", {11'b0, 6'h33}});
        tick(1);
        it = sb.pop_front();
        n_checks++;
        if (raw_joystick1 !== it.exp[5:0]) $display("FAIL %s: got %h expected %h", it.name, raw_joystick1, it.exp[5:0]);
        else n_pass++;
        joy_0 = 10'h000;
        tick(2);
    endtask

    task automatic test_merge();
        step_t    steps[$];
        sb_item_t it;
        steps.push_back(st("joy0_fire",       0, 11'h010, 1, e_j1(6'h2F)));
        steps.push_back(st("joy0_idle",       0, 11'h000, 1, IDLE));
        steps.push_back(st("joy1_jump",       1, 11'h020, 1, e_j2(6'h1F)));
        steps.push_back(st("joy1_start1",     1, 11'h040, 1, e_st(2'b10)));
        steps.push_back(st("joy1_start2",     1, 11'h080, 1, e_st(2'b01)));
        steps.push_back(st("joy1_idle",       1, 11'h000, 1, IDLE));
        steps.push_back(st("joy0_both_start", 0, 11'h0C0, 1, e_st(2'b00)));
        steps.push_back(st("joy0_idle2",      0, 11'h000, 1, IDLE));
        steps.push_back(st("jam1_up",         2, 11'h008, 3, e_j1(6'h37)));
        steps.push_back(st("jam1_start",      2, 11'h040, 3, e_st(2'b10)));
        steps.push_back(st("jam1_idle",       2, 11'h000, 3, IDLE));
        steps.push_back(st("jam2_b1",         3, 11'h010, 3, e_j2(6'h2F)));
        steps.push_back(st("jam2_start",      3, 11'h040, 3, e_st(2'b01)));
        steps.push_back(st("jam2_lr_socd",    3, 11'h003, 3, IDLE));
        steps.push_back(st("jam2_idle",       3, 11'h000, 3, IDLE));
        steps.push_back(st("kbd_f1_press",    4, 11'h105, 2, e_st(2'b10)));
        steps.push_back(st("kbd_f1_release",  4, 11'h005, 2, IDLE));
        steps.push_back(st("kbd_f2_press",    4, 11'h106, 2, e_st(2'b01)));
        steps.push_back(st("kbd_f2_release",  4, 11'h006, 2, IDLE));
        foreach (steps[i]) begin
            apply(steps[i]);
            for (int k = 1; k <= steps[i].lat; k++)
                sb.push_back('{$sformatf("%s@%0d", steps[i].name, k),
                               (k < steps[i].lat) ? exp_now : steps[i].exp});
            for (int k = 1; k <= steps[i].lat; k++) begin
                tick(1);
                it = sb.pop_front();
                n_checks++;
                if (obs() !== it.exp) $display("FAIL %s: got %h expected %h", it.name, obs(), it.exp);
                else n_pass++;
            end
            exp_now = steps[i].exp;
        end
    endtask

    task automatic test_pause();
        step_t    steps[$];
        sb_item_t it;
        steps.push_back(st("f4_press",          4, 11'h10C, 2, e_p(1'b1)));
        steps.push_back(st("f4_release",        4, 11'h00C, 2, e_p(1'b1)));
        steps.push_back(st("f4_press_again",    4, 11'h10C, 2, e_p(1'b0)));
        steps.push_back(st("f4_release_again",  4, 11'h00C, 2, e_p(1'b0)));
        steps.push_back(st("joy1_pause_softrst",1, 11'h600, 1, e_p(1'b0)));
        steps.push_back(st("joy1_pause_clear",  1, 11'h000, 1, e_p(1'b0)));
        steps.push_back(st("joy1_pause_edge",   1, 11'h200, 1, e_p(1'b1)));
        steps.push_back(st("joy1_pause_rel",    1, 11'h000, 1, e_p(1'b1)));
        steps.push_back(st("softrst_clears",    1, 11'h400, 1, e_p(1'b0)));
        steps.push_back(st("softrst_held_edge", 1, 11'h600, 1, e_p(1'b0)));
        steps.push_back(st("softrst_held_rel",  1, 11'h400, 1, e_p(1'b0)));
        steps.push_back(st("softrst_release",   1, 11'h000, 1, e_p(1'b0)));
        foreach (steps[i]) begin
            apply(steps[i]);
            for (int k = 1; k <= steps[i].lat; k++)
                sb.push_back('{$sformatf("%s@%0d", steps[i].name, k),
                               (k < steps[i].lat) ? exp_now : steps[i].exp});
            for (int k = 1; k <= steps[i].lat; k++) begin
                tick(1);
                it = sb.pop_front();
                n_checks++;
                if (obs() !== it.exp) $display("FAIL %s: got %h expected %h", it.name, obs(), it.exp);
                else n_pass++;
            end
            exp_now = steps[i].exp;
        end
    endtask

    task automatic test_coin();
        string names[4]  = '{"coin_single", "coin_retrigger", "coin_held", "coin_jamma2"};
        int    ch[4]     = '{0, 0, 0, 1};
        int    hold[4]   = '{1, 1, 20, 1};
        int    retrig[4] = '{0, 4, 0, 0};
        int    first_exp[4] = '{1, 1, 1, 3};
        for (int s = 0; s < 4; s++) begin
            int   first;
            int   lows;
            int   other;
            logic lvl;
            first = -1; lows = 0; other = 0;
            for (int i = 1; i <= 30; i++) begin
                lvl = (i <= hold[s]) || (i == retrig[s]);
                if (ch[s] == 0) joy_0[8] = lvl;
                else            jamma_p2[7] = lvl;
                tick(1);
                if (coin_input[ch[s]] === 1'b0) begin
                    if (first < 0) first = i;
                    lows++;
                end
                if (coin_input[1 - ch[s]] !== 1'b1) other++;
            end
            n_checks++;
            if (first != first_exp[s]) $display("FAIL %s_start: got cycle %0d expected %0d", names[s], first, first_exp[s]);
            else n_pass++;
            n_checks++;
            if (lows != 8) $display("FAIL %s_width: got %0d low cycles expected 8", names[s], lows);
            else n_pass++;
            n_checks++;
            if (other != 0) $display("FAIL %s_other_chan: got %0d low cycles expected 0", names[s], other);
            else n_pass++;
            tick(2);
        end
    endtask

    task automatic test_reset_midpulse();
        int lows;
        joy_0[8] = 1'b1;
        tick(1);
        joy_0[8] = 1'b0;
        tick(2);
        n_checks++;
        if (coin_input !== 2'b10) $display("FAIL midpulse_active: got %b expected 10", coin_input);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (coin_input !== 2'b11) $display("FAIL midpulse_async_clear: got %b expected 11", coin_input);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (coin_input !== 2'b11) lows++;
        end
        n_checks++;
        if (lows != 0) $display("FAIL midpulse_residual: got %0d active cycles expected 0", lows);
        else n_pass++;
        n_checks++;
        if (obs() !== IDLE) $display("FAIL midpulse_idle: got %h expected %h", obs(), IDLE);
        else n_pass++;
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_key  = '0;
        joy_0    = '0;
        joy_1    = '0;
        jamma_p1 = '0;
        jamma_p2 = '0;
        soft_rst = 1'b0;
        exp_now  = IDLE;
        tick(1);
        test_reset();
        test_ps2();
        test_socd();
        test_merge();
        test_coin();
        test_pause();
        test_reset_midpulse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
